// File: rtl/bp_be_pkg.sv
// Shared types for the backend stride detector: config enum, FSM states and
// the stride-table entry struct macro (instantiated per module with its widths).
package bp_be_pkg;

  typedef enum logic [0:0] {e_bp_default_cfg} bp_params_e;

  function automatic int bp_vaddr_width(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 39;
      default:          return 39;
    endcase
  endfunction

  typedef enum logic [1:0] {
    e_stride_idle,
    e_stride_announce,
    e_stride_wait
  } bp_be_stride_state_e;

endpackage

`define BP_BE_STRIDE_ENTRY_S_DECLARE(vaddr_width_mp, stride_width_mp, conf_bits_mp) \
  typedef struct packed {                                                          \
    logic                              v;                                          \
    logic [vaddr_width_mp-1:0]         tag;                                        \
    logic [vaddr_width_mp-1:0]         last_addr;                                  \
    logic signed [stride_width_mp-1:0] stride;                                     \
    logic [conf_bits_mp-1:0]           conf;                                       \
    logic                              reported;                                   \
  } bp_be_stride_entry_s

// File: rtl/bp_be_stride_table.sv
// Fully-associative PC-tagged stride table with round-robin allocation.
// BP_BE_STRIDE_NEGATIVE_EN lets descending (negative) strides train.
module bp_be_stride_table
  import bp_be_pkg::*;
  #(parameter int vaddr_width_p  = 39,
    parameter int entries_p      = 8,
    parameter int conf_bits_p    = 2,
    parameter int stride_width_p = 16)
  (input  logic                      clk_i,
   input  logic                      reset,
   input  logic                      v,
   input  logic [vaddr_width_p-1:0]  pc,
   input  logic [vaddr_width_p-1:0]  eaddr,
   input  logic                      set_reported,
   output logic                      hit,
   output logic [conf_bits_p-1:0]    conf,
   output logic                      reported,
   output logic [stride_width_p-1:0] stride);

  `BP_BE_STRIDE_ENTRY_S_DECLARE(vaddr_width_p, stride_width_p, conf_bits_p);

  localparam int idx_w = $clog2(entries_p);

  bp_be_stride_entry_s tbl_r [entries_p];
  logic [idx_w-1:0]    victim_r;

  logic [entries_p-1:0]     match;
  logic [idx_w-1:0]         hit_idx;
  logic [vaddr_width_p-1:0] delta;
  logic                     fits, sign_ok, stride_ok, same;
  bp_be_stride_entry_s      entry_new, entry_wr, entry_alloc;

  always_comb begin
    match   = '0;
    hit_idx = '0;
    for (int i = 0; i < entries_p; i++) begin
      match[i] = tbl_r[i].v && (tbl_r[i].tag == pc);
      // tags are unique, so OR-ing indices of matching entries yields the one hit
      if (match[i]) hit_idx = hit_idx | idx_w'(i);
    end
  end

  assign hit   = v && (|match);
  assign delta = eaddr - tbl_r[hit_idx].last_addr;
  assign fits  = (&delta[vaddr_width_p-1:stride_width_p-1])
              || ~(|delta[vaddr_width_p-1:stride_width_p-1]);

`ifdef BP_BE_STRIDE_NEGATIVE_EN
  assign sign_ok = 1'b1;
`else
  assign sign_ok = ~delta[vaddr_width_p-1];
`endif

  assign stride_ok = fits && sign_ok;
  assign same      = stride_ok && (delta != '0)
                  && (delta[stride_width_p-1:0] == tbl_r[hit_idx].stride);

  always_comb begin
    entry_new           = tbl_r[hit_idx];
    entry_new.last_addr = eaddr;
    if (same) begin
      if (entry_new.conf != '1) entry_new.conf = entry_new.conf + 1'b1;
    end else begin
      entry_new.stride   = stride_ok ? delta[stride_width_p-1:0] : '0;
      entry_new.conf     = '0;
      entry_new.reported = 1'b0;
    end
    entry_wr          = entry_new;
    entry_wr.reported = entry_new.reported | set_reported;
    entry_alloc = '{v: 1'b1, tag: pc, last_addr: eaddr, stride: '0, conf: '0, reported: 1'b0};
  end

  assign conf     = entry_new.conf;
  assign reported = entry_new.reported;
  assign stride   = entry_new.stride;

  always_ff @(posedge clk_i) begin
    if (reset) begin
      for (int i = 0; i < entries_p; i++) tbl_r[i] <= '0;
      victim_r <= '0;
    end else if (v) begin
      if (hit) begin
        tbl_r[hit_idx] <= entry_wr;
      end else begin
        tbl_r[victim_r] <= entry_alloc;
        victim_r        <= victim_r + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bp_be_stride_detector.sv
// Announces a confidently striding load PC to the loop inference block, then
// waits for its result (done_i) or a watchdog. Feature macro: BP_BE_STRIDE_NEGATIVE_EN.
module bp_be_stride_detector
  import bp_be_pkg::*;
  #(parameter bp_params_e bp_params_p = e_bp_default_cfg,
    parameter int entries_p      = 8,
    parameter int conf_bits_p    = 2,
    parameter int conf_thresh_p  = 3,
    parameter int stride_width_p = 16,
    parameter int timeout_p      = 1024,
    localparam int vaddr_width_p = bp_vaddr_width(bp_params_p))
  (input  logic                      clk_i,
   input  logic                      reset,
   input  logic                      v_i,
   input  logic [vaddr_width_p-1:0]  pc_i,
   input  logic [vaddr_width_p-1:0]  eaddr_i,
   output logic                      start_discovery_o,
   output logic [vaddr_width_p-1:0]  striding_pc_o,
   output logic [stride_width_p-1:0] stride_o,
   input  logic                      done_i,
   output logic                      busy_o);

  localparam int wd_w = (timeout_p > 1) ? $clog2(timeout_p) : 1;

  bp_be_stride_state_e state_r, state_n;
  logic [wd_w-1:0]     wd_r;

  logic                      hit, reported, eligible;
  logic [conf_bits_p-1:0]    conf;
  logic [stride_width_p-1:0] stride_new;

  bp_be_stride_table
    #(.vaddr_width_p(vaddr_width_p), .entries_p(entries_p),
      .conf_bits_p(conf_bits_p), .stride_width_p(stride_width_p))
    table_inst
    (.clk_i(clk_i), .reset(reset), .v(v_i), .pc(pc_i), .eaddr(eaddr_i),
     .set_reported(eligible), .hit(hit), .conf(conf), .reported(reported),
     .stride(stride_new));

  // Training never stops; only the announcement is gated on IDLE.
  assign eligible = hit && (conf >= conf_bits_p'(conf_thresh_p)) && !reported
                 && (state_r == e_stride_idle);

  always_comb begin
    state_n = state_r;
    case (state_r)
      e_stride_idle:     if (eligible) state_n = e_stride_announce;
      e_stride_announce: state_n = e_stride_wait;
      e_stride_wait:     if (done_i || (wd_r == wd_w'(timeout_p - 1))) state_n = e_stride_idle;
      default:           state_n = e_stride_idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_r       <= e_stride_idle;
      wd_r          <= '0;
      striding_pc_o <= '0;
      stride_o      <= '0;
    end else begin
      state_r <= state_n;
      if (state_r == e_stride_announce) wd_r <= '0;
      else if (state_r == e_stride_wait) wd_r <= wd_r + 1'b1;
      if (eligible) begin
        striding_pc_o <= pc_i;
        stride_o      <= stride_new;
      end
    end
  end

  assign start_discovery_o = (state_r == e_stride_announce);
  assign busy_o            = (state_r == e_stride_wait);

endmodule

// File: tb/tb_bp_be_stride_detector.sv
// Randomized bench for bp_be_stride_detector against a behavioural model of the
// stride table and announce window; honours BP_BE_STRIDE_NEGATIVE_EN.
module tb_bp_be_stride_detector;
  import bp_be_pkg::*;

  localparam int VW        = bp_vaddr_width(e_bp_default_cfg);
  localparam int ENTRIES   = 8;
  localparam int CONF_BITS = 2;
  localparam int THRESH    = 3;
  localparam int SW        = 16;
  localparam int TIMEOUT   = 40;
  localparam int CONF_MAX  = (1 << CONF_BITS) - 1;
  localparam longint LIM   = longint'(1) << (SW - 1);
`ifdef BP_BE_STRIDE_NEGATIVE_EN
  localparam bit NEG_EN = 1'b1;
`else
  localparam bit NEG_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, v, done;
  logic [VW-1:0] pc, eaddr;
  logic          start, busy;
  logic [VW-1:0] spc;
  logic [SW-1:0] stride;

  bp_be_stride_detector
    #(.bp_params_p(e_bp_default_cfg), .entries_p(ENTRIES), .conf_bits_p(CONF_BITS),
      .conf_thresh_p(THRESH), .stride_width_p(SW), .timeout_p(TIMEOUT))
    dut
    (.clk_i(clk), .reset(reset), .v_i(v), .pc_i(pc), .eaddr_i(eaddr),
     .start_discovery_o(start), .striding_pc_o(spc), .stride_o(stride),
     .done_i(done), .busy_o(busy));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model
  bit            model_live = 1'b0;
  bit            m_valid [ENTRIES];
  logic [VW-1:0] m_tag   [ENTRIES];
  logic [VW-1:0] m_last  [ENTRIES];
  longint        m_stride[ENTRIES];
  int            m_conf  [ENTRIES];
  bit            m_rep   [ENTRIES];
  int            m_victim;
  bit            m_ann;
  int            m_left;
  logic [VW-1:0] m_pc;
  longint        m_str;

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = '0; m_last[i] = '0;
      m_stride[i] = 0; m_conf[i] = 0; m_rep[i] = 1'b0;
    end
    m_victim = 0; m_ann = 1'b0; m_left = 0; m_pc = '0; m_str = 0;
  endtask

  task automatic model_step();
    int            hit;
    bit            idle, elig, ok;
    logic [VW-1:0] d;
    longint        sd;
    model_live = 1'b1;
    if (reset) begin
      model_reset();
      return;
    end
    idle = !m_ann && (m_left == 0);
    elig = 1'b0;
    if (v) begin
      hit = -1;
      for (int i = 0; i < ENTRIES; i++)
        if (m_valid[i] && m_tag[i] == pc) hit = i;
      if (hit < 0) begin
        m_valid[m_victim] = 1'b1; m_tag[m_victim] = pc; m_last[m_victim] = eaddr;
        m_stride[m_victim] = 0; m_conf[m_victim] = 0; m_rep[m_victim] = 1'b0;
        m_victim = (m_victim + 1) % ENTRIES;
      end else begin
        d  = eaddr - m_last[hit];
        sd = $signed({{(64-VW){d[VW-1]}}, d});
        ok = (sd >= -LIM) && (sd < LIM) && (NEG_EN || sd >= 0);
        if (ok && sd != 0 && sd == m_stride[hit]) begin
          m_conf[hit] = (m_conf[hit] < CONF_MAX) ? m_conf[hit] + 1 : CONF_MAX;
        end else begin
          m_stride[hit] = ok ? sd : 0;
          m_conf[hit]   = 0;
          m_rep[hit]    = 1'b0;
        end
        m_last[hit] = eaddr;
        if (idle && m_conf[hit] >= THRESH && !m_rep[hit]) begin
          elig = 1'b1; m_rep[hit] = 1'b1; m_pc = pc; m_str = m_stride[hit];
        end
      end
    end
    if (m_ann) begin
      m_ann  = 1'b0;
      m_left = TIMEOUT;
    end else if (m_left > 0) begin
      m_left = done ? 0 : m_left - 1;
    end else if (elig) begin
      m_ann = 1'b1;
    end
  endtask

  // compare process
  always @(negedge clk) begin
    if (model_live) begin
      chk("start_discovery_o", 64'(start), 64'(m_ann));
      chk("busy_o",            64'(busy),  64'(m_left > 0));
      chk("striding_pc_o",     64'(spc),   64'(m_pc));
      chk("stride_o",          64'(stride), 64'(m_str[SW-1:0]));
    end
  end

  // driver tasks
  task automatic cyc(input bit vv, input logic [VW-1:0] p, input logic [VW-1:0] e, input bit d);
    v = vv; pc = p; eaddr = e; done = d;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic ld(input logic [VW-1:0] p, input logic [VW-1:0] e);
    cyc(1'b1, p, e, 1'b0);
  endtask

  task automatic idle_cyc();
    cyc(1'b0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) idle_cyc();
    reset = 1'b0;
  endtask

  logic [VW-1:0] r_next [12];
  longint        r_str  [12];

  function automatic longint pick_stride();
    case ($urandom_range(0, 5))
      0: return 8;
      1: return 16;
      2: return -8;
      3: return 4;
      4: return 0;
      default: return 64'h12345;
    endcase
  endfunction

  initial begin
    int cnt, k;
    reset = 1'b1; v = 1'b0; done = 1'b0; pc = '0; eaddr = '0;
    do_reset();
    chk("reset_start",  64'(start),  64'd0);
    chk("reset_busy",   64'(busy),   64'd0);
    chk("reset_pc",     64'(spc),    64'd0);
    chk("reset_stride", 64'(stride), 64'd0);

    // basic +8 stride: pulse right after the fifth load
    for (int i = 0; i < 4; i++) ld(VW'('h1000), VW'('h8000 + 8*i));
    chk("t1_no_early_pulse", 64'(start), 64'd0);
    ld(VW'('h1000), VW'('h8020));
    chk("t1_pulse", 64'(start),  64'd1);
    chk("t1_pc",    64'(spc),    64'h1000);
    chk("t1_stride",64'(stride), 64'd8);
    idle_cyc();
    chk("t1_busy",  64'(busy),   64'd1);

    // second PC trains during WAIT, announces only after done_i
    for (int i = 0; i < 5; i++) ld(VW'('h2000), VW'('hA000 + 4*i));
    chk("t2_gated", 64'(start), 64'd0);
    cyc(1'b0, '0, '0, 1'b1);
    chk("t2_done_idle", 64'(busy), 64'd0);
    ld(VW'('h2000), VW'('hA014));
    chk("t2_pulse",  64'(start),  64'd1);
    chk("t2_pc",     64'(spc),    64'h2000);
    chk("t2_stride", 64'(stride), 64'd4);
    idle_cyc();

    // watchdog: WAIT lasts exactly TIMEOUT cycles
    cnt = 0;
    while (busy && cnt < 3 * TIMEOUT) begin
      cnt++;
      idle_cyc();
    end
    chk("t3_wait_len", 64'(cnt), 64'(TIMEOUT));
    ld(VW'('h2000), VW'('hA018));
    chk("t3_no_reannounce", 64'(start), 64'd0);

    // stride break 4 -> 16 re-arms the reported PC
    for (int i = 1; i <= 3; i++) ld(VW'('h2000), VW'('hA018 + 16*i));
    chk("t4_no_early", 64'(start), 64'd0);
    ld(VW'('h2000), VW'('hA058));
    chk("t4_pulse",  64'(start),  64'd1);
    chk("t4_stride", 64'(stride), 64'd16);
    idle_cyc();
    cyc(1'b0, '0, '0, 1'b1);

    // descending stride
    for (int i = 0; i < 5; i++) ld(VW'('h3000), VW'('h9000 - 8*i));
    chk("t5_pulse",  64'(start),  64'(NEG_EN));
    chk("t5_pc",     64'(spc),    NEG_EN ? 64'h3000 : 64'h2000);
    chk("t5_stride", 64'(stride), NEG_EN ? 64'hfff8 : 64'd16);
    idle_cyc();
    cyc(1'b0, '0, '0, 1'b1);

    // reset in the middle of WAIT
    for (int i = 0; i < 5; i++) ld(VW'('h6000), VW'('hC000 + 8*i));
    chk("t6_pulse", 64'(start), 64'd1);
    idle_cyc();
    chk("t6_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    idle_cyc();
    chk("t6_reset_busy",  64'(busy),  64'd0);
    chk("t6_reset_start", 64'(start), 64'd0);
    idle_cyc();
    reset = 1'b0;

    // eviction: ninth PC replaces entry 0, first PC re-allocates into entry 1
    for (int i = 0; i < 9; i++) ld(VW'('h100 * (i + 1)), VW'('h20000 + 'h1000 * i));
    for (int j = 0; j < 4; j++) ld(VW'('h100), VW'('h20008 + 8*j));
    chk("t7_miss_no_pulse", 64'(start), 64'd0);
    ld(VW'('h100), VW'('h20028));
    chk("t7_pulse", 64'(start), 64'd1);
    chk("t7_pc",    64'(spc),   64'h100);
    ld(VW'('h300), VW'('h22008));
    cyc(1'b0, '0, '0, 1'b1);

    // randomized traffic
    for (int i = 0; i < 12; i++) begin
      r_next[i] = VW'('h40000 + 'h10000 * i);
      r_str[i]  = pick_stride();
    end
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 999) == 0) reset = 1'b1;
      k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 11)) : int'($urandom_range(0, 4));
      if ($urandom_range(0, 3) != 0) begin
        cyc(1'b1, VW'('h5000 + 'h40 * k), r_next[k], $urandom_range(0, 7) == 0);
        r_next[k] = r_next[k] + VW'(r_str[k]);
        if ($urandom_range(0, 15) == 0) r_str[k] = pick_stride();
      end else begin
        cyc(1'b0, '0, '0, $urandom_range(0, 7) == 0);
      end
      reset = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
